// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game state: board, cursor, turn and win/draw status,
// exported to the VGA side as a snapshot that only changes on frame_start.
module ttt_board_ctrl #(
  parameter logic [1:0] FIRST_MARK = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_move,
  input  logic        btn_place,
  input  logic        btn_new,
  input  logic        frame_start,
  output logic [17:0] board,
  output logic [3:0]  cursor,
  output logic [1:0]  turn,
  output logic [1:0]  status,
  output logic [8:0]  win_line,
  output logic        illegal
);

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

  // Cells of each line, lowest-priority line last.
  localparam logic [3:0] LA [8] = '{4'd0, 4'd3, 4'd6, 4'd0,
                                    4'd1, 4'd2, 4'd0, 4'd2};
  localparam logic [3:0] LB [8] = '{4'd1, 4'd4, 4'd7, 4'd3,
                                    4'd4, 4'd5, 4'd4, 4'd4};
  localparam logic [3:0] LC [8] = '{4'd2, 4'd5, 4'd8, 4'd6,
                                    4'd7, 4'd8, 4'd8, 4'd6};

  state_t      state;
  logic [17:0] cells;
  logic [3:0]  cur;
  logic [1:0]  trn;
  logic [3:0]  cnt;
  logic [8:0]  wl;
  logic [1:0]  st_code;
  logic        prev_move;
  logic        prev_place;
  logic        prev_new;
  logic        move_e;
  logic        place_e;
  logic        new_e;
  logic        hit;
  logic [8:0]  hit_mask;
  logic [1:0]  ma;
  logic [1:0]  mb;
  logic [1:0]  mc;
  logic [1:0]  cur_cell;

  assign move_e   = btn_move & ~prev_move;
  assign place_e  = btn_place & ~prev_place;
  assign new_e    = btn_new & ~prev_new;
  assign cur_cell = cells[{cur, 1'b0} +: 2];

  always_comb begin
    st_code = 2'b00;
    if (state == WIN)  st_code = 2'b01;
    if (state == DRAW) st_code = 2'b10;
  end

  // Scan from the last line down so the lowest-numbered match wins.
  always_comb begin
    hit      = 1'b0;
    hit_mask = 9'd0;
    ma       = 2'b00;
    mb       = 2'b00;
    mc       = 2'b00;
    for (int i = 7; i >= 0; i--) begin
      ma = cells[{LA[i], 1'b0} +: 2];
      mb = cells[{LB[i], 1'b0} +: 2];
      mc = cells[{LC[i], 1'b0} +: 2];
      if (ma != 2'b00 && ma == mb && mb == mc) begin
        hit      = 1'b1;
        hit_mask = (9'd1 << LA[i]) | (9'd1 << LB[i])
                 | (9'd1 << LC[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= PLAY;
      cells      <= '0;
      cur        <= '0;
      trn        <= FIRST_MARK;
      cnt        <= '0;
      wl         <= '0;
      prev_move  <= 1'b1;
      prev_place <= 1'b1;
      prev_new   <= 1'b1;
      illegal    <= 1'b0;
      board      <= '0;
      cursor     <= '0;
      turn       <= FIRST_MARK;
      status     <= 2'b00;
      win_line   <= '0;
    end else begin
      prev_move  <= btn_move;
      prev_place <= btn_place;
      prev_new   <= btn_new;
      illegal    <= 1'b0;
      if (frame_start) begin
        board    <= cells;
        cursor   <= cur;
        turn     <= trn;
        status   <= st_code;
        win_line <= wl;
      end
      if (new_e) begin
        state <= PLAY;
        cells <= '0;
        cur   <= '0;
        trn   <= FIRST_MARK;
        cnt   <= '0;
        wl    <= '0;
      end else begin
        unique case (state)
          PLAY: begin
            if (place_e) begin
              if (cur_cell == 2'b00) begin
                cells[{cur, 1'b0} +: 2] <= trn;
                cnt   <= cnt + 4'd1;
                state <= CHECK;
              end else begin
                illegal <= 1'b1;
              end
            end else if (move_e) begin
              cur <= (cur == 4'd8) ? 4'd0 : cur + 4'd1;
            end
          end
          CHECK: begin
            if (hit) begin
              wl    <= hit_mask;
              state <= WIN;
            end else if (cnt == 4'd9) begin
              state <= DRAW;
            end else begin
              trn   <= ~trn;
              state <= PLAY;
            end
          end
          WIN, DRAW: ;
          default: state <= PLAY;
        endcase
      end
    end
  end

endmodule

// File: doc/ttt_board_ctrl.md
# ttt_board_ctrl

Game-state stage that sits directly upstream of the VGA controller. It holds the contents of the 3x3 tic-tac-toe board, the cursor position, whose turn it is, and the win/draw status. It is driven by debounced push-buttons. It presents a frame-stable snapshot of the board so the VGA controller can colour each grid cell without tearing.

## Interface
Parameters:
- FIRST_MARK, 2'b01, mark placed by the first player after reset or new game (2'b01 = X, 2'b10 = O).

Ports:
- clk  in  1  system clock; the same clock the VGA controller divides down.
- rst  in  1  synchronous, active-low reset.
- btn_move  in  1  debounced level; each rising edge advances the cursor.
- btn_place  in  1  debounced level; each rising edge places the current mark at the cursor.
- btn_new  in  1  debounced level; each rising edge starts a new game.
- frame_start  in  1  one-clk pulse from the VGA side at the start of vertical blanking.
- board  out  18  display snapshot; cell c occupies bits [2c+1:2c]. Codes: 00 empty, 01 X, 10 O, 11 never driven.
- cursor  out  4  display snapshot of the cursor index, 0..8.
- turn  out  2  display snapshot of the mark that will be placed next (01/10).
- status  out  2  display snapshot: 00 playing, 01 win, 10 draw.
- win_line  out  9  display snapshot; one bit per cell, set on the three cells of the winning line, otherwise 0.
- illegal  out  1  one-clk pulse, not snapshotted; asserted on a place attempt onto an occupied cell.

## Operation
- Cell index is row-major: c = row*3 + col, with cell 0 top-left and cell 8 bottom-right.
- Edge detection:
  - Each button has a previous-value register.
  - An edge is counted in the cycle where the input is 1 and its previous-value register is 0.
  - Previous-value registers reset to 1, so a button held through reset is not counted until it is released and pressed again.
- Priority within one cycle: new > place > move. Lower-priority edges in the same cycle are discarded, not queued.
- FSM states are PLAY, CHECK, WIN and DRAW.
  - Reset and new game both force: board empty, cursor 0, turn = FIRST_MARK, move count 0, state PLAY.
- PLAY:
  - move edge: cursor increments; 8 wraps to 0.
  - place edge on an empty cell: write turn into the cell, increment move count, go to CHECK.
  - place edge on an occupied cell: pulse illegal; state, board and cursor are unchanged.
- CHECK (exactly one cycle) evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) for three equal non-empty marks:
  - Any line matches: go to WIN and load win_line with that line's cells. If more than one line matches, use the lowest-numbered line (rows 0-2, then columns 0-2, then the main diagonal, then the anti-diagonal).
  - No match and move count = 9: go to DRAW.
  - Otherwise: toggle turn and return to PLAY.
  - Button edges arriving during CHECK are discarded, except new.
- WIN/DRAW: move and place edges are ignored; only new leaves these states. turn keeps the mark of the last placer.
- Move count is 4 bits and never exceeds 9.

## Timing
- Reset: all internal state and all outputs take their reset values on the first clk edge with rst = 0.
  - Output reset values: board 0, cursor 0, turn FIRST_MARK, status 00, win_line 0, illegal 0.
- An edge is sampled at clk edge N; internal state reflects the action at N+1.
- Place to result: cell written at N+1, CHECK occupies N+1, and WIN/DRAW/turn toggle are visible internally at N+2.
- illegal is high for the single cycle N+1.
- Snapshot outputs (board, cursor, turn, status, win_line):
  - Each is loaded from internal state on the clk edge where frame_start = 1, and holds otherwise.
  - If frame_start coincides with an internal update, the snapshot captures the pre-update values.
- rst = 0 mid-game or mid-CHECK clears everything on the next clk edge, with no partial commit.
- Minimum press spacing: one place per 2 cycles; faster edges are discarded by CHECK.

## Test plan
- Reset with btn_place held high: after rst is released, no placement occurs and board reads 0 after a frame_start. Release and press btn_place: cell 0 becomes 01.
- X at cells 0, 1, 2 and O at 3, 4 (cursor stepped with btn_move), each followed by frame_start: status = 01, win_line = 9'b000000111, turn = 01, and further btn_place presses leave board unchanged.
- Place on cell 0, then press place again on cell 0: illegal pulses for 1 cycle, turn stays 10, and board[1:0] stays 01.
- Draw order X0, O1, X2, O4, X3, O5, X7, O6, X8: status = 10 after the ninth placement and win_line = 0.
- Press btn_new and btn_place in the same cycle mid-game: board 0, cursor 0, turn FIRST_MARK, no illegal pulse. Nine btn_move presses return the cursor to 0.
- Place with no frame_start: outputs stay unchanged. A frame_start pulse in the same cycle as the board write: old board is captured. The next frame_start shows the new board.
